// File: rtl/armleocpu_ptw.sv
// armleocpu_ptw -- Sv32 hardware page-table walker (TLB refill engine).
//
// On a TLB miss the walker reads the root PTE and, when that PTE is a pointer,
// one more PTE from the next level, through a single-outstanding read port. A
// valid leaf is written into the TLB. A bad PTE or a bus error is reported as a
// fault instead, and a fault never writes the TLB.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   resolve_request            start a walk (sampled only when idle)
//   resolve_virtual_address    VPN {vpn1, vpn0}, latched on accept
//   satp_ppn                   root page-table PPN, latched on accept
//   resolve_done               one-cycle completion pulse
//   resolve_pagefault/accessfault  fault flags, valid with done
//   resolve_physical_address   leaf PPN (superpage leaves merge vpn0)
//   resolve_access_bits        leaf PTE[7:0] (DAGUXWRV)
//   mem_read/address/readdata/done/error   PTE read port
//   tlb_write, tlb_*_w         TLB refill write port
module armleocpu_ptw #(
    parameter bit CHECK_ACCESSED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resolve_request,
    input  logic [19:0] resolve_virtual_address,
    input  logic [21:0] satp_ppn,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [21:0] resolve_physical_address,
    output logic [7:0]  resolve_access_bits,
    output logic        mem_read,
    output logic [33:0] mem_address,
    input  logic [31:0] mem_readdata,
    input  logic        mem_done,
    input  logic        mem_error,
    output logic        tlb_write,
    output logic [19:0] tlb_virtual_address_w,
    output logic [21:0] tlb_phys_w,
    output logic [7:0]  tlb_accesstag_w
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        level_q, level_d;      // 1: root level, 0: second level
    logic [33:0] addr_q, addr_d;
    logic [19:0] vpn_q, vpn_d;
    logic        pf_q, pf_d;
    logic        af_q, af_d;
    logic [21:0] phys_q, phys_d;
    logic [7:0]  bits_q, bits_d;

    logic pte_v, pte_r, pte_w, pte_x, pte_a;
    assign pte_v = mem_readdata[0];
    assign pte_r = mem_readdata[1];
    assign pte_w = mem_readdata[2];
    assign pte_x = mem_readdata[3];
    assign pte_a = mem_readdata[6];

    // RSW bits carry no meaning for translation.
    logic unused_rsw;
    assign unused_rsw = ^mem_readdata[9:8];

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        addr_d  = addr_q;
        vpn_d   = vpn_q;
        pf_d    = pf_q;
        af_d    = af_q;
        phys_d  = phys_q;
        bits_d  = bits_q;
        case (state_q)
            ST_IDLE: begin
                if (resolve_request) begin
                    vpn_d   = resolve_virtual_address;
                    level_d = 1'b1;
                    addr_d  = {satp_ppn, resolve_virtual_address[19:10], 2'b00};
                    pf_d    = 1'b0;
                    af_d    = 1'b0;
                    phys_d  = '0;
                    bits_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (mem_done) begin
                    if (mem_error) begin
                        af_d    = 1'b1;
                        state_d = ST_DONE;
                    end else if (!pte_v || (!pte_r && pte_w)) begin
                        pf_d    = 1'b1;
                        state_d = ST_DONE;
                    end else if (pte_r || pte_x) begin
                        // Leaf: a root-level leaf must have ppn0 == 0.
                        if ((level_q && (mem_readdata[19:10] != 10'd0)) ||
                            (CHECK_ACCESSED && !pte_a)) begin
                            pf_d = 1'b1;
                        end else begin
                            phys_d = level_q ? {mem_readdata[31:20], vpn_q[9:0]}
                                             : mem_readdata[31:10];
                            bits_d = mem_readdata[7:0];
                        end
                        state_d = ST_DONE;
                    end else if (!level_q) begin
                        // Pointer at the last level has nowhere to go.
                        pf_d    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        // Pointer: issue the second-level read straight away,
                        // mem_read stays high and the new address is a new request.
                        addr_d  = {mem_readdata[31:10], vpn_q[9:0], 2'b00};
                        level_d = 1'b0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= 1'b0;
            addr_q  <= '0;
            vpn_q   <= '0;
            pf_q    <= 1'b0;
            af_q    <= 1'b0;
            phys_q  <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            addr_q  <= addr_d;
            vpn_q   <= vpn_d;
            pf_q    <= pf_d;
            af_q    <= af_d;
            phys_q  <= phys_d;
            bits_q  <= bits_d;
        end
    end

    assign mem_read                 = (state_q == ST_READ);
    assign mem_address              = addr_q;
    assign resolve_done             = (state_q == ST_DONE);
    assign resolve_pagefault        = pf_q;
    assign resolve_accessfault      = af_q;
    assign resolve_physical_address = phys_q;
    assign resolve_access_bits      = bits_q;
    assign tlb_write                = (state_q == ST_DONE) && !pf_q && !af_q;
    assign tlb_virtual_address_w    = vpn_q;
    assign tlb_phys_w               = phys_q;
    assign tlb_accesstag_w          = bits_q;

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Directed bench for armleocpu_ptw. A small PTE memory (two address/data
// entries with per-entry response delay and an optional error address)
// answers the walker's reads; every expected value is hand-computed.
module tb_armleocpu_ptw;

    logic        clk;
    logic        rst_n;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic [21:0] satp_ppn;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_access_bits;
    logic        mem_read;
    logic [33:0] mem_address;
    logic [31:0] mem_readdata;
    logic        mem_done;
    logic        mem_error;
    logic        tlb_write;
    logic [19:0] tlb_virtual_address_w;
    logic [21:0] tlb_phys_w;
    logic [7:0]  tlb_accesstag_w;

    armleocpu_ptw #(.CHECK_ACCESSED(1'b1)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .resolve_request          (resolve_request),
        .resolve_virtual_address  (resolve_virtual_address),
        .satp_ppn                 (satp_ppn),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_physical_address (resolve_physical_address),
        .resolve_access_bits      (resolve_access_bits),
        .mem_read                 (mem_read),
        .mem_address              (mem_address),
        .mem_readdata             (mem_readdata),
        .mem_done                 (mem_done),
        .mem_error                (mem_error),
        .tlb_write                (tlb_write),
        .tlb_virtual_address_w    (tlb_virtual_address_w),
        .tlb_phys_w               (tlb_phys_w),
        .tlb_accesstag_w          (tlb_accesstag_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PTE memory model
    logic [33:0] m_a0, m_a1, err_a;
    logic [31:0] m_d0, m_d1;
    int          dly0, dly1;
    logic        err_en;
    int          wait_cnt;
    int          n_reads;
    logic [33:0] prev_addr;
    logic        hold_prev;
    int          n_unstable;

    assign mem_readdata = (mem_address == m_a0) ? m_d0 :
                          (mem_address == m_a1) ? m_d1 : 32'h0;
    assign mem_done  = mem_read && (wait_cnt >= ((mem_address == m_a1) ? dly1 : dly0));
    assign mem_error = mem_read && err_en && (mem_address == err_a);

    always @(posedge clk) begin
        if (mem_read && !mem_done) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (rst_n && mem_read && mem_done) n_reads <= n_reads + 1;
        hold_prev <= mem_read && !mem_done;
        prev_addr <= mem_address;
    end

    always @(negedge clk) begin
        if (hold_prev && mem_read && (mem_address != prev_addr)) n_unstable <= n_unstable + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issue a request and wait for done; lat = negedges after the accepting edge.
    task automatic walk(input logic [19:0] va, input logic [21:0] satp, output int lat);
        @(negedge clk);
        resolve_request         = 1'b1;
        resolve_virtual_address = va;
        satp_ppn                = satp;
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            resolve_request = 1'b0;
            lat++;
            if (resolve_done) break;
        end
        if (!resolve_done) chk("done_timeout", 64'(resolve_done), 64'd1);
    endtask

    // Result check at the done cycle, then verify the pulse lasts one cycle
    // and the result is held afterwards.
    task automatic result(input string tag, input int lat, input int exp_lat,
                          input logic pf, input logic af,
                          input logic [21:0] phys, input logic [7:0] bits);
        chk({tag, "_lat"},   64'(lat), 64'(exp_lat));
        chk({tag, "_pf"},    64'(resolve_pagefault), 64'(pf));
        chk({tag, "_af"},    64'(resolve_accessfault), 64'(af));
        chk({tag, "_tlbw"},  64'(tlb_write), 64'(!pf && !af));
        chk({tag, "_phys"},  64'(resolve_physical_address), 64'(phys));
        chk({tag, "_bits"},  64'(resolve_access_bits), 64'(bits));
        if (!pf && !af) begin
            chk({tag, "_tphys"}, 64'(tlb_phys_w), 64'(phys));
            chk({tag, "_ttag"},  64'(tlb_accesstag_w), 64'(bits));
        end
        @(negedge clk);
        chk({tag, "_pulse"},    64'(resolve_done), 64'd0);
        chk({tag, "_tlbw_off"}, 64'(tlb_write), 64'd0);
        chk({tag, "_hold"},     64'({resolve_pagefault, resolve_physical_address}), 64'({pf, phys}));
    endtask

    task automatic mem_cfg(input logic [33:0] a0, input logic [31:0] d0,
                           input logic [33:0] a1, input logic [31:0] d1);
        m_a0 = a0; m_d0 = d0; m_a1 = a1; m_d1 = d1;
        dly0 = 0; dly1 = 0; err_en = 1'b0; err_a = '0;
    endtask

    int lat, r0, dcnt;

    initial begin
        n_reads = 0; wait_cnt = 0; n_unstable = 0; hold_prev = 1'b0; prev_addr = '0;
        rst_n = 1'b0; resolve_request = 1'b0; resolve_virtual_address = '0; satp_ppn = '0;
        mem_cfg(34'h3FFFFFFFF, 32'h0, 34'h3FFFFFFFF, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_done",     64'(resolve_done), 64'd0);
        chk("rst_tlbw",     64'(tlb_write), 64'd0);
        chk("rst_faults",   64'({resolve_pagefault, resolve_accessfault}), 64'd0);
        chk("rst_data",     64'({resolve_physical_address, resolve_access_bits}), 64'd0);
        chk("rst_addr",     64'(mem_address), 64'd0);
        rst_n = 1'b1;

        // 1: superpage leaf at root level
        mem_cfg(34'h1000, 32'h0000_00CF, 34'h3FFFFFFFF, 32'h0);
        r0 = n_reads;
        walk({10'h000, 10'h155}, 22'h1, lat);
        chk("t1_va", 64'(tlb_virtual_address_w), 64'h00155);
        chk("t1_reads", 64'(n_reads - r0), 64'd1);
        result("t1", lat, 2, 1'b0, 1'b0, 22'h000155, 8'hCF);

        // 2: two-level walk
        mem_cfg(34'h1200, 32'h0000_1001, 34'h4004, 32'h0040_00C7);
        r0 = n_reads;
        walk(20'h2_0001, 22'h1, lat);
        chk("t2_addr2", 64'(mem_address), 64'h4004);
        chk("t2_reads", 64'(n_reads - r0), 64'd2);
        chk("t2_va", 64'(tlb_virtual_address_w), 64'h20001);
        result("t2", lat, 3, 1'b0, 1'b0, 22'h001000, 8'hC7);

        // 3: invalid root PTE; pointer at level 0
        mem_cfg(34'h1000, 32'h0, 34'h3FFFFFFFF, 32'h0);
        walk({10'h000, 10'h155}, 22'h1, lat);
        result("t3_inv", lat, 2, 1'b1, 1'b0, 22'h0, 8'h0);
        mem_cfg(34'h1000, 32'h0000_1001, 34'h4554, 32'h0000_1001);
        walk({10'h000, 10'h155}, 22'h1, lat);
        result("t3_ptr0", lat, 3, 1'b1, 1'b0, 22'h0, 8'h0);

        // 4: misaligned superpage, W without R, A clear
        mem_cfg(34'h1000, 32'h0000_04CF, 34'h3FFFFFFFF, 32'h0);
        walk({10'h000, 10'h155}, 22'h1, lat);
        result("t4_misal", lat, 2, 1'b1, 1'b0, 22'h0, 8'h0);
        mem_cfg(34'h1000, 32'h0000_00C5, 34'h3FFFFFFFF, 32'h0);
        walk({10'h000, 10'h155}, 22'h1, lat);
        result("t4_wnr", lat, 2, 1'b1, 1'b0, 22'h0, 8'h0);
        mem_cfg(34'h1000, 32'h0000_000F, 34'h3FFFFFFFF, 32'h0);
        walk({10'h000, 10'h155}, 22'h1, lat);
        result("t4_noa", lat, 2, 1'b1, 1'b0, 22'h0, 8'h0);

        // 5: bus error on the delayed second read
        mem_cfg(34'h1200, 32'h0000_1001, 34'h4004, 32'h0040_00C7);
        dly1 = 3; err_en = 1'b1; err_a = 34'h4004;
        n_unstable = 0;
        walk(20'h2_0001, 22'h1, lat);
        chk("t5_addr_stable", 64'(n_unstable), 64'd0);
        chk("t5_addr", 64'(mem_address), 64'h4004);
        result("t5", lat, 6, 1'b0, 1'b1, 22'h0, 8'h0);

        // 6: reset in the middle of a read abandons the walk
        mem_cfg(34'h1000, 32'h0000_00CF, 34'h3FFFFFFFF, 32'h0);
        dly0 = 10;
        @(negedge clk);
        resolve_request = 1'b1; resolve_virtual_address = {10'h000, 10'h155}; satp_ppn = 22'h1;
        @(negedge clk);
        resolve_request = 1'b0;
        chk("t6_reading", 64'(mem_read), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_read", 64'(mem_read), 64'd0);
        chk("t6_rst_done", 64'(resolve_done), 64'd0);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resolve_done || mem_read) dcnt++;
        end
        chk("t6_no_done", 64'(dcnt), 64'd0);
        dly0 = 0;
        walk({10'h000, 10'h155}, 22'h1, lat);
        result("t6_after", lat, 2, 1'b0, 1'b0, 22'h000155, 8'hCF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
